// File: rtl/mem_req_arbiter_pkg.sv
// Shared widths, memory size/response encodings and arbiter state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_req_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  // Request size; NONE doubles as "no request pending".
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  // Slave response codes.
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ    = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE   = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_FAULT   = 2'd3;

  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_rr_priority_picker.sv
// Round-robin winner select: first pending index at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; winner is all-zero when nothing is pending.
//   pending    : one bit per requester with a live request
//   ptr        : index that has highest priority this round
//   winner     : one-hot winner
//   winner_idx : binary index of the winner (0 when nothing pending)
module mem_req_arbiter_rr_priority_picker #(
  parameter int REQ_COUNT = 2,
  parameter int IDX_W     = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] pending,
  input  logic [IDX_W-1:0]     ptr,
  output logic [REQ_COUNT-1:0] winner,
  output logic [IDX_W-1:0]     winner_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      // Walk the requesters starting at ptr, wrapping at REQ_COUNT.
      idx = IDX_W'((int'(ptr) + i) % REQ_COUNT);
      if (!found && pending[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin sharing of one memory slave port between REQ_COUNT requesters, one transaction at a time.
// Latency: SLAVE_LATENCY+1 edges from request sample to o_res_valid; back-to-back grants SLAVE_LATENCY+3 cycles apart.
// Backpressure: requesters hold their request until o_res_valid[k]; the request is latched at grant, later changes are ignored.
//   clk, aresetn         : clock, async active-low reset
//   i_req_*              : packed per-requester request fields; count==MEM_COUNT_NONE means idle
//   o_res_*              : per-requester captured response slots plus one-cycle valid pulse
//   o_grant              : one-hot current owner, 0 when idle
//   o_slv_req_* / i_slv_res_* : slave request (registered) and slave response
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int REQ_COUNT     = 2,
  parameter int SLAVE_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [REQ_COUNT*ADDR_W-1:0]       i_req_addr,
  input  logic [REQ_COUNT*WORD_W-1:0]       i_req_wr_data,
  input  logic [REQ_COUNT-1:0]              i_req_wr_en,
  input  logic [REQ_COUNT*MEM_COUNT_W-1:0]  i_req_count,
  output logic [REQ_COUNT*WORD_W-1:0]       o_res_rd_data,
  output logic [REQ_COUNT*MEM_CODE_W-1:0]   o_res_code,
  output logic [REQ_COUNT-1:0]              o_res_valid,
  output logic [REQ_COUNT-1:0]              o_grant,
  output logic [ADDR_W-1:0]                 o_slv_req_addr,
  output logic [WORD_W-1:0]                 o_slv_req_wr_data,
  output logic                              o_slv_req_wr_en,
  output logic [MEM_COUNT_W-1:0]            o_slv_req_count,
  input  logic [WORD_W-1:0]                 i_slv_res_rd_data,
  input  logic [MEM_CODE_W-1:0]             i_slv_res_code
);

  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam int CNT_W = $clog2(SLAVE_LATENCY + 1);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       grant_idx;
  logic [CNT_W-1:0]       cnt;
  logic [REQ_COUNT-1:0]   pending;
  logic [REQ_COUNT-1:0]   win_onehot;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_pending;
  logic                   start;
  logic                   capture;
  logic                   finish;
  logic                   lat_done;

  always_comb begin
    pending = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      pending[k] = (i_req_count[k*MEM_COUNT_W +: MEM_COUNT_W] != MEM_COUNT_NONE);
    end
  end

  assign any_pending = |pending;
  assign lat_done    = (cnt == CNT_W'(SLAVE_LATENCY));

  mem_req_arbiter_rr_priority_picker #(
    .REQ_COUNT (REQ_COUNT),
    .IDX_W     (IDX_W)
  ) u_picker (
    .pending    (pending),
    .ptr        (ptr),
    .winner     (win_onehot),
    .winner_idx (win_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (any_pending) state_nxt = ARB_BUSY;
      ARB_BUSY: if (lat_done)    state_nxt = ARB_RESP;
      ARB_RESP:                  state_nxt = ARB_IDLE;
      default:                   state_nxt = ARB_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath registers.
  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state)
      ARB_IDLE: start   = any_pending;
      ARB_BUSY: capture = lat_done;
      ARB_RESP: finish  = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: the slave-side registers double as the request latch.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr               <= '0;
      grant_idx         <= '0;
      cnt               <= '0;
      o_grant           <= '0;
      o_res_valid       <= '0;
      o_res_rd_data     <= '0;
      o_res_code        <= '0;
      o_slv_req_addr    <= '0;
      o_slv_req_wr_data <= '0;
      o_slv_req_wr_en   <= 1'b0;
      o_slv_req_count   <= MEM_COUNT_NONE;
    end else begin
      if (start) begin
        grant_idx         <= win_idx;
        o_grant           <= win_onehot;
        cnt               <= '0;
        o_slv_req_addr    <= i_req_addr[win_idx*ADDR_W +: ADDR_W];
        o_slv_req_wr_data <= i_req_wr_data[win_idx*WORD_W +: WORD_W];
        o_slv_req_wr_en   <= i_req_wr_en[win_idx];
        o_slv_req_count   <= i_req_count[win_idx*MEM_COUNT_W +: MEM_COUNT_W];
      end
      if (state == ARB_BUSY) begin
        if (capture) begin
          o_res_rd_data[grant_idx*WORD_W +: WORD_W]      <= i_slv_res_rd_data;
          o_res_code[grant_idx*MEM_CODE_W +: MEM_CODE_W] <= i_slv_res_code;
          o_res_valid[grant_idx]                         <= 1'b1;
          ptr <= (grant_idx == IDX_W'(REQ_COUNT - 1)) ? '0 : grant_idx + IDX_W'(1);
          // Slave port goes idle during the response cycle.
          o_slv_req_addr    <= '0;
          o_slv_req_wr_data <= '0;
          o_slv_req_wr_en   <= 1'b0;
          o_slv_req_count   <= MEM_COUNT_NONE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (finish) begin
        o_grant     <= '0;
        o_res_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (2 requesters, slave latency 1) with a single-bank GPIO slave model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int RC  = 2;
  localparam int LAT = 1;

  logic                         clk = 1'b0;
  logic                         aresetn;
  logic [RC*ADDR_W-1:0]         i_req_addr;
  logic [RC*WORD_W-1:0]         i_req_wr_data;
  logic [RC-1:0]                i_req_wr_en;
  logic [RC*MEM_COUNT_W-1:0]    i_req_count;
  logic [RC*WORD_W-1:0]         o_res_rd_data;
  logic [RC*MEM_CODE_W-1:0]     o_res_code;
  logic [RC-1:0]                o_res_valid;
  logic [RC-1:0]                o_grant;
  logic [ADDR_W-1:0]            o_slv_req_addr;
  logic [WORD_W-1:0]            o_slv_req_wr_data;
  logic                         o_slv_req_wr_en;
  logic [MEM_COUNT_W-1:0]       o_slv_req_count;
  logic [WORD_W-1:0]            i_slv_res_rd_data;
  logic [MEM_CODE_W-1:0]        i_slv_res_code;
  logic [WORD_W-1:0]            gpio_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .REQ_COUNT     (RC),
    .SLAVE_LATENCY (LAT)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .i_req_addr        (i_req_addr),
    .i_req_wr_data     (i_req_wr_data),
    .i_req_wr_en       (i_req_wr_en),
    .i_req_count       (i_req_count),
    .o_res_rd_data     (o_res_rd_data),
    .o_res_code        (o_res_code),
    .o_res_valid       (o_res_valid),
    .o_grant           (o_grant),
    .o_slv_req_addr    (o_slv_req_addr),
    .o_slv_req_wr_data (o_slv_req_wr_data),
    .o_slv_req_wr_en   (o_slv_req_wr_en),
    .o_slv_req_count   (o_slv_req_count),
    .i_slv_res_rd_data (i_slv_res_rd_data),
    .i_slv_res_code    (i_slv_res_code)
  );

  // Single-bank GPIO slave at address 0, one-edge response latency.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      gpio_state        <= '0;
      i_slv_res_rd_data <= '0;
      i_slv_res_code    <= MEM_CODE_INVALID;
    end else if (o_slv_req_count != MEM_COUNT_NONE) begin
      if (o_slv_req_addr != '0) begin
        i_slv_res_rd_data <= '0;
        i_slv_res_code    <= MEM_CODE_FAULT;
      end else if (o_slv_req_wr_en) begin
        gpio_state        <= o_slv_req_wr_data;
        i_slv_res_rd_data <= '0;
        i_slv_res_code    <= MEM_CODE_WRITE;
      end else begin
        i_slv_res_rd_data <= gpio_state;
        i_slv_res_code    <= MEM_CODE_READ;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [MEM_COUNT_W-1:0] cnt, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data);
    i_req_count[k*MEM_COUNT_W +: MEM_COUNT_W] = cnt;
    i_req_wr_en[k]                            = we;
    i_req_addr[k*ADDR_W +: ADDR_W]            = addr;
    i_req_wr_data[k*WORD_W +: WORD_W]         = data;
  endtask

  task automatic drop(input int k);
    set_req(k, MEM_COUNT_NONE, 1'b0, '0, '0);
  endtask

  function automatic logic [63:0] slot_rd(input int k);
    return 64'(o_res_rd_data[k*WORD_W +: WORD_W]);
  endfunction

  function automatic logic [63:0] slot_code(input int k);
    return 64'(o_res_code[k*MEM_CODE_W +: MEM_CODE_W]);
  endfunction

  initial begin
    logic [RC-1:0] exp_g;
    aresetn       = 1'b0;
    i_req_addr    = '0;
    i_req_wr_data = '0;
    i_req_wr_en   = '0;
    i_req_count   = '0;

    // 1. Reset values and quiet idle.
    step(2);
    chk("rst_grant",   64'(o_grant), 64'h0);
    chk("rst_valid",   64'(o_res_valid), 64'h0);
    chk("rst_slv_cnt", 64'(o_slv_req_count), 64'(MEM_COUNT_NONE));
    chk("rst_slv_adr", 64'(o_slv_req_addr), 64'h0);
    chk("rst_slv_we",  64'(o_slv_req_wr_en), 64'h0);
    chk("rst_rd",      64'(o_res_rd_data), 64'h0);
    chk("rst_code",    64'(o_res_code), 64'h0);
    aresetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("idle_grant",   64'(o_grant), 64'h0);
      chk("idle_valid",   64'(o_res_valid), 64'h0);
      chk("idle_slv_cnt", 64'(o_slv_req_count), 64'(MEM_COUNT_NONE));
    end

    // 2. Requester 0 writes deadbeef to address 0.
    set_req(0, MEM_COUNT_WORD, 1'b1, 32'h0, 32'hdeadbeef);
    step(1);
    chk("t2_grant_c0", 64'(o_grant), 64'h1);
    chk("t2_valid_c0", 64'(o_res_valid), 64'h0);
    chk("t2_slv_cnt",  64'(o_slv_req_count), 64'(MEM_COUNT_WORD));
    chk("t2_slv_wd",   64'(o_slv_req_wr_data), 64'hdeadbeef);
    chk("t2_slv_we",   64'(o_slv_req_wr_en), 64'h1);
    step(1);
    chk("t2_grant_c1", 64'(o_grant), 64'h1);
    chk("t2_valid_c1", 64'(o_res_valid), 64'h0);
    step(1);
    chk("t2_grant_c2", 64'(o_grant), 64'h1);
    chk("t2_valid_c2", 64'(o_res_valid), 64'h1);
    chk("t2_code0",    slot_code(0), 64'(MEM_CODE_WRITE));
    chk("t2_slv_idle", 64'(o_slv_req_count), 64'(MEM_COUNT_NONE));
    drop(0);
    step(1);
    chk("t2_grant_end", 64'(o_grant), 64'h0);
    chk("t2_valid_end", 64'(o_res_valid), 64'h0);
    chk("t2_gpio",      64'(gpio_state), 64'hdeadbeef);

    // 3. Requester 1 reads it back; slot 0 untouched.
    set_req(1, MEM_COUNT_WORD, 1'b0, 32'h0, 32'h0);
    step(1);
    chk("t3_grant_c0", 64'(o_grant), 64'h2);
    chk("t3_slv_we",   64'(o_slv_req_wr_en), 64'h0);
    step(1);
    chk("t3_valid_c1", 64'(o_res_valid), 64'h0);
    step(1);
    chk("t3_valid_c2", 64'(o_res_valid), 64'h2);
    chk("t3_rd1",      slot_rd(1), 64'hdeadbeef);
    chk("t3_code1",    slot_code(1), 64'(MEM_CODE_READ));
    chk("t3_rd0",      slot_rd(0), 64'h0);
    chk("t3_code0",    slot_code(0), 64'(MEM_CODE_WRITE));
    drop(1);
    step(1);
    chk("t3_grant_end", 64'(o_grant), 64'h0);

    // 4. Both pending from reset, held: grants alternate 01,10,01,10.
    aresetn = 1'b0;
    set_req(0, MEM_COUNT_WORD, 1'b1, 32'h0, 32'h000000a5);
    set_req(1, MEM_COUNT_WORD, 1'b0, 32'h0, 32'h0);
    step(2);
    aresetn = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      step(1);
      chk("t4_grant_c0", 64'(o_grant), 64'(exp_g));
      chk("t4_valid_c0", 64'(o_res_valid), 64'h0);
      step(1);
      chk("t4_grant_c1", 64'(o_grant), 64'(exp_g));
      chk("t4_valid_c1", 64'(o_res_valid), 64'h0);
      step(1);
      chk("t4_grant_c2", 64'(o_grant), 64'(exp_g));
      chk("t4_valid_c2", 64'(o_res_valid), 64'(exp_g));
      if (g == 1) chk("t4_rd1", slot_rd(1), 64'h000000a5);
      step(1);
      chk("t4_grant_c3", 64'(o_grant), 64'h0);
      chk("t4_valid_c3", 64'(o_res_valid), 64'h0);
    end
    drop(0);
    drop(1);

    // 5. Requester 1 changes wr_data mid-BUSY; slave keeps the latched value.
    set_req(1, MEM_COUNT_WORD, 1'b1, 32'h0, 32'h0badf00d);
    step(1);
    chk("t5_grant_c0", 64'(o_grant), 64'h2);
    chk("t5_slv_wd0",  64'(o_slv_req_wr_data), 64'h0badf00d);
    i_req_wr_data[WORD_W +: WORD_W] = 32'h12345678;
    step(1);
    chk("t5_grant_c1", 64'(o_grant), 64'h2);
    chk("t5_slv_wd1",  64'(o_slv_req_wr_data), 64'h0badf00d);
    step(1);
    chk("t5_valid_c2", 64'(o_res_valid), 64'h2);
    chk("t5_code1",    slot_code(1), 64'(MEM_CODE_WRITE));
    drop(1);
    step(1);
    chk("t5_gpio",     64'(gpio_state), 64'h0badf00d);

    // 6. Move ptr to 1, then reset in the middle of a requester-1 transaction.
    set_req(0, MEM_COUNT_WORD, 1'b0, 32'h0, 32'h0);
    step(1);
    chk("t6_pre_grant", 64'(o_grant), 64'h1);
    step(2);
    chk("t6_pre_valid", 64'(o_res_valid), 64'h1);
    chk("t6_pre_rd0",   slot_rd(0), 64'h0badf00d);
    drop(0);
    step(1);
    set_req(1, MEM_COUNT_WORD, 1'b0, 32'h0, 32'h0);
    step(1);
    chk("t6_busy_grant", 64'(o_grant), 64'h2);
    step(1);
    chk("t6_busy_valid", 64'(o_res_valid), 64'h0);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_grant",  64'(o_grant), 64'h0);
    chk("t6_rst_valid",  64'(o_res_valid), 64'h0);
    chk("t6_rst_slvcnt", 64'(o_slv_req_count), 64'(MEM_COUNT_NONE));
    chk("t6_rst_rd",     64'(o_res_rd_data), 64'h0);
    set_req(0, MEM_COUNT_WORD, 1'b1, 32'h0, 32'hcafef00d);
    step(1);
    chk("t6_no_pulse",   64'(o_res_valid), 64'h0);
    aresetn = 1'b1;
    step(1);
    chk("t6_ptr0_grant", 64'(o_grant), 64'h1);
    step(2);
    chk("t6_valid",      64'(o_res_valid), 64'h1);
    chk("t6_code0",      slot_code(0), 64'(MEM_CODE_WRITE));
    chk("t6_code1",      slot_code(1), 64'h0);
    drop(0);
    drop(1);
    step(1);
    chk("t6_grant_end",  64'(o_grant), 64'h0);
    chk("t6_gpio",       64'(gpio_state), 64'hcafef00d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
